// File: rtl/datamem_pkg.sv
// Shared definitions for the data memory controller.
// Holds the controller state encoding, the data word width, the default
// response latency and the width of the latency down-counter.
package datamem_pkg;

  localparam int DATA_W          = 32;
  localparam int DEFAULT_LATENCY = 3;
  localparam int CNT_W           = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/datamem_array.sv
// Single-port backing store: synchronous write, registered read.
// Ports:
//   clk      - clock
//   i_en     - access enable (write when i_we, otherwise read)
//   i_we     - write enable
//   i_addr   - word index
//   i_wdata  - write data
//   o_rdata  - read data, valid the cycle after a read access
module datamem_array
  import datamem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [AW-1:0]     i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH_WORDS];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        r_mem[i_addr] <= i_wdata;
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller with fixed response latency.
// Accepts one read or write request at a time, performs the array access
// LATENCY-1 edges after acceptance and raises MemValid_wire for one cycle
// exactly LATENCY edges after acceptance. Requests seen while busy are dropped.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   MemRead_wire          - read request
//   MemWrite_wire         - write request (wins over a simultaneous read)
//   MemAddress_wire       - byte address
//   MemWriteData_wire     - write data
//   Datamem_wire          - response data (written data for writes)
//   MemValid_wire         - one-cycle response strobe
//   MemBusy_wire          - request in flight
//   MemErr_wire           - only with DATAMEM_ERR_EN: misaligned / out-of-range
// Build option: define DATAMEM_ERR_EN to add address error reporting; without
// it the word index simply wraps modulo DEPTH_WORDS.
module data_mem_ctrl
  import datamem_pkg::*;
#(
  parameter int LATENCY     = DEFAULT_LATENCY,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MemRead_wire,
  input  logic              MemWrite_wire,
  input  logic [31:0]       MemAddress_wire,
  input  logic [DATA_W-1:0] MemWriteData_wire,
  output logic [DATA_W-1:0] Datamem_wire,
  output logic              MemValid_wire,
`ifdef DATAMEM_ERR_EN
  output logic              MemErr_wire,
`endif
  output logic              MemBusy_wire
);

  localparam int             AW       = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [31:0]       r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_is_write;
  logic              r_err;
  logic              r_resp_err;
  logic              r_valid;
  logic [DATA_W-1:0] r_datamem;

  logic              w_req, w_accept, w_access;
  logic [31:0]       w_acc_addr;
  logic [DATA_W-1:0] w_acc_wdata;
  logic              w_acc_write, w_acc_err;
  logic              w_mem_en, w_mem_we;
  logic [DATA_W-1:0] w_rdata;

  assign w_req = MemRead_wire | MemWrite_wire;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_access    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          w_accept = 1'b1;
          if (LATENCY == 1) begin
            // Access happens on the accepting edge itself.
            w_state_nxt = ST_RESP;
            w_access    = 1'b1;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = CNT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (r_cnt == CNT_ONE) begin
          w_state_nxt = ST_RESP;
          w_access    = 1'b1;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // In IDLE the only access is the LATENCY==1 case, which uses the live inputs.
  assign w_acc_addr  = (r_state == ST_IDLE) ? MemAddress_wire   : r_addr;
  assign w_acc_wdata = (r_state == ST_IDLE) ? MemWriteData_wire : r_wdata;
  assign w_acc_write = (r_state == ST_IDLE) ? MemWrite_wire     : r_is_write;

`ifdef DATAMEM_ERR_EN
  assign w_acc_err = (w_acc_addr[1:0] != 2'b00) ||
                     (w_acc_addr >= 32'(DEPTH_WORDS * 4));
`else
  logic w_unused_addr;
  assign w_acc_err     = 1'b0;
  assign w_unused_addr = ^{MemAddress_wire[31:AW+2], MemAddress_wire[1:0],
                           r_addr[31:AW+2], r_addr[1:0]};
`endif

  // Gate with rst_n so nothing is committed on an edge while reset is held.
  assign w_mem_en = w_access & rst_n;
  assign w_mem_we = w_acc_write & ~w_acc_err;

  datamem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk     (clk),
    .i_en    (w_mem_en),
    .i_we    (w_mem_we),
    .i_addr  (w_acc_addr[AW+1:2]),
    .i_wdata (w_acc_wdata),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_valid    <= 1'b0;
      r_datamem  <= '0;
      r_err      <= 1'b0;
      r_resp_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_valid    <= (r_state == ST_RESP);
      r_resp_err <= (r_state == ST_RESP) & r_err;
      if (w_access) begin
        r_err <= w_acc_err;
      end
      // Response data is taken from the registered array output (reads) or the
      // latched write data, and only changes together with the strobe.
      if (r_state == ST_RESP) begin
        r_datamem <= r_err ? '0 : (r_is_write ? r_wdata : w_rdata);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_addr     <= MemAddress_wire;
      r_wdata    <= MemWriteData_wire;
      r_is_write <= MemWrite_wire;
    end
  end

  assign Datamem_wire  = r_datamem;
  assign MemValid_wire = r_valid;
  assign MemBusy_wire  = (r_state != ST_IDLE);
`ifdef DATAMEM_ERR_EN
  assign MemErr_wire   = r_resp_err;
`endif

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: a LATENCY=3 instance under directed and
// random traffic plus a LATENCY=1 instance for back-to-back behaviour.
module tb_data_mem_ctrl;

  localparam int LAT   = 3;
  localparam int DEPTH = 1024;
  localparam int AWB   = $clog2(DEPTH);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        rd, wr, rd1, wr1;
  logic [31:0] addr, wdata, addr1, wdata1;
  logic [31:0] dout, dout1;
  logic        vld, busy, vld1, busy1;
`ifdef DATAMEM_ERR_EN
  logic        err, err1;
`endif

  data_mem_ctrl #(.LATENCY(LAT), .DEPTH_WORDS(DEPTH)) u_dut (
    .clk(clk), .rst_n(rst_n), .MemRead_wire(rd), .MemWrite_wire(wr),
    .MemAddress_wire(addr), .MemWriteData_wire(wdata), .Datamem_wire(dout),
    .MemValid_wire(vld),
`ifdef DATAMEM_ERR_EN
    .MemErr_wire(err),
`endif
    .MemBusy_wire(busy)
  );

  data_mem_ctrl #(.LATENCY(1), .DEPTH_WORDS(DEPTH)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .MemRead_wire(rd1), .MemWrite_wire(wr1),
    .MemAddress_wire(addr1), .MemWriteData_wire(wdata1), .Datamem_wire(dout1),
    .MemValid_wire(vld1),
`ifdef DATAMEM_ERR_EN
    .MemErr_wire(err1),
`endif
    .MemBusy_wire(busy1)
  );

  typedef struct {
    int          resp_cyc;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: request accepted at edge e when idle -> strobe after edge
  // e+LAT, busy after edges e..e+LAT-1, next acceptance possible at e+LAT+1.
  txn_t        exp_q[$];
  logic [31:0] mdl_mem [DEPTH];
  bit          mdl_known [DEPTH];
  int          next_free  = 0;
  int          busy_until = -1;

  txn_t        q1[$];
  logic [31:0] mem1 [int];
  int          next_free1  = 0;
  int          busy_until1 = -1;
  int          pulses1     = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h (edge %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'(a[AWB+1:2]);
  endfunction

  task automatic step(input logic r, input logic w, input logic [31:0] a,
                      input logic [31:0] d);
    txn_t t;
    rd = r; wr = w; addr = a; wdata = d;
    @(posedge clk); #1;
    if (rst_n && (r || w) && cyc >= next_free) begin
      t.resp_cyc = cyc + LAT; t.wr = w; t.addr = a; t.data = d;
      exp_q.push_back(t);
      next_free  = cyc + LAT + 1;
      busy_until = cyc + LAT - 1;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic step1(input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d);
    txn_t t;
    rd1 = r; wr1 = w; addr1 = a; wdata1 = d;
    @(posedge clk); #1;
    if (rst_n && (r || w) && cyc >= next_free1) begin
      t.resp_cyc = cyc + 1; t.wr = w; t.addr = a;
      if (w) begin
        t.data = d;
        mem1[idx_of(a)] = d;
      end else begin
        t.data = mem1.exists(idx_of(a)) ? mem1[idx_of(a)] : 32'h0;
      end
      q1.push_back(t);
      next_free1  = cyc + 2;
      busy_until1 = cyc;
    end
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid", {31'h0, vld}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_data", dout, 32'h0);
    exp_q.delete();
    busy_until = -1;
    next_free  = 0;
    @(posedge clk); #3;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin : mon
    txn_t t;
    bit   er;
    int   ix;
    if (rst_n) begin
      check("busy", {31'h0, busy}, {31'h0, (cyc <= busy_until)});
      if (vld) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL valid_unexpected: MemValid=1 at edge %0d, required 0", cyc);
        end else begin
          t = exp_q.pop_front();
          check("resp_edge", cyc, t.resp_cyc);
          ix = idx_of(t.addr);
`ifdef DATAMEM_ERR_EN
          er = (t.addr[1:0] != 2'b00) || (t.addr >= 32'(DEPTH * 4));
          check("err_flag", {31'h0, err}, {31'h0, er});
`else
          er = 1'b0;
`endif
          if (er) begin
            check("data_err", dout, 32'h0);
          end else if (t.wr) begin
            check("wdata_ret", dout, t.data);
            mdl_mem[ix]   = t.data;
            mdl_known[ix] = 1'b1;
          end else if (mdl_known[ix]) begin
            check("rdata", dout, mdl_mem[ix]);
          end
        end
      end else if (exp_q.size() != 0 && exp_q[0].resp_cyc <= cyc) begin
        checks++; errors++;
        $display("FAIL valid_missing: MemValid=0 at edge %0d, required 1", cyc);
        void'(exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin : mon1
    txn_t t;
    if (rst_n) begin
      check("busy_l1", {31'h0, busy1}, {31'h0, (cyc <= busy_until1)});
      if (vld1) begin
        pulses1++;
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL valid_l1_unexpected: MemValid=1 at edge %0d, required 0", cyc);
        end else begin
          t = q1.pop_front();
          check("resp_edge_l1", cyc, t.resp_cyc);
          check("data_l1", dout1, t.data);
        end
      end else if (q1.size() != 0 && q1[0].resp_cyc <= cyc) begin
        checks++; errors++;
        $display("FAIL valid_l1_missing: MemValid=0 at edge %0d, required 1", cyc);
        void'(q1.pop_front());
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0] a;
    int          hold;
    logic        r, w;
    rst_n = 1'b0;
    rd = 0; wr = 0; addr = 0; wdata = 0;
    rd1 = 0; wr1 = 0; addr1 = 0; wdata1 = 0;
    @(posedge clk); #1;
    check("reset_valid", {31'h0, vld}, 32'h0);
    check("reset_busy", {31'h0, busy}, 32'h0);
    check("reset_data", dout, 32'h0);
    @(posedge clk); #3;
    rst_n = 1'b1;

    // Seed words used by the directed cases.
    step(1'b0, 1'b1, 32'h0000_0000, 32'h0BAD_F00D); idle(LAT + 1);
    step(1'b0, 1'b1, 32'h0000_0010, 32'h1111_2222); idle(LAT + 1);

    // Write then read back.
    step(1'b0, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF); idle(LAT + 1);
    step(1'b1, 1'b0, 32'h0000_0040, 32'h0);         idle(LAT + 1);

    // Read and write together: write wins and is returned.
    step(1'b1, 1'b1, 32'h0000_0080, 32'h1234_5678); idle(LAT + 1);
    step(1'b1, 1'b0, 32'h0000_0080, 32'h0);         idle(LAT + 1);

    // Second read during WAIT is dropped.
    step(1'b1, 1'b0, 32'h0000_0040, 32'h0);
    step(1'b1, 1'b0, 32'h0000_0080, 32'h0);
    idle(LAT + 1);

    // Reset during WAIT aborts the pending write.
    step(1'b0, 1'b1, 32'h0000_0010, 32'hAAAA_5555);
    rd = 0; wr = 0;
    pulse_reset();
    idle(LAT + 1);
    step(1'b1, 1'b0, 32'h0000_0010, 32'h0); idle(LAT + 1);

    // Misaligned address beyond the array.
    step(1'b1, 1'b0, 32'h0000_1001, 32'h0); idle(LAT + 1);

    // Random traffic, including requests held across busy periods.
    for (int n = 0; n < 250; n++) begin
      a = 32'($urandom_range(0, 31)) << 2;
      if ($urandom_range(0, 7) == 0) a = a | (32'($urandom_range(1, 3)) << 12);
      if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
      r    = 1'($urandom_range(0, 1));
      w    = ($urandom_range(0, 2) == 0);
      hold = $urandom_range(1, 6);
      for (int k = 0; k < hold; k++) step(r, w, a, $urandom);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
    end
    idle(LAT + 2);
    check("queue_drained", exp_q.size(), 32'h0);

    // LATENCY=1 instance: write, then a read held for six cycles.
    step1(1'b0, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF);
    step1(1'b0, 1'b0, 32'h0, 32'h0);
    step1(1'b0, 1'b0, 32'h0, 32'h0);
    for (int k = 0; k < 6; k++) step1(1'b1, 1'b0, 32'h0000_0040, 32'h0);
    for (int k = 0; k < 3; k++) step1(1'b0, 1'b0, 32'h0, 32'h0);
    check("pulses_l1", pulses1, 32'd4);
    check("queue_l1_drained", q1.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
